// File: rtl/desip_axil_slave_if.sv
// AXI4-Lite bus bundle between the system master and the DES register front-end.
interface desip_axil_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/desip_axil_slave.sv
// AXI4-Lite register front-end for the DES core: key/data words, start pulse,
// busy/done status and captured result.
module desip_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    desip_axil_slave_if.slave   s_axi,
    output logic [63:0]         des_key,
    output logic [63:0]         des_din,
    output logic                des_decrypt,
    output logic                des_start,
    input  logic                des_done,
    input  logic [63:0]         des_dout
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

    logic [DW-1:0] r_key_hi, r_key_lo, r_din_hi, r_din_lo;
    logic [DW-1:0] r_res_hi, r_res_lo;
    logic          r_decrypt, r_busy, r_done, r_start;
    logic          r_rdy_en;
    logic          r_aw_full, r_w_full, r_bvalid, r_rvalid;
    logic [IW-1:0] r_aw_addr;
    logic [DW-1:0] r_w_data, r_rdata;
    logic [SW-1:0] r_w_strb;

    logic          w_awready, w_wready, w_arready;
    logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [IW-1:0] w_wr_addr;
    logic [DW-1:0] w_wr_data, w_rd_mux;
    logic [SW-1:0] w_wr_strb;
    logic          w_start_req, w_done_clr, w_core_done;
    logic          w_unused_ok;

    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                              input logic [DW-1:0] new_v,
                                              input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // Readies stay low during reset and while a write response is outstanding.
    assign w_awready = r_rdy_en & ~r_aw_full & ~r_bvalid;
    assign w_wready  = r_rdy_en & ~r_w_full & ~r_bvalid;
    assign w_arready = r_rdy_en & ~r_rvalid;

    assign w_aw_hs = s_axi.S_AXI_AWVALID & w_awready;
    assign w_w_hs  = s_axi.S_AXI_WVALID & w_wready;
    assign w_ar_hs = s_axi.S_AXI_ARVALID & w_arready;

    assign w_wr_addr = r_aw_full ? r_aw_addr : s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wr_data = r_w_full ? r_w_data : s_axi.S_AXI_WDATA;
    assign w_wr_strb = r_w_full ? r_w_strb : s_axi.S_AXI_WSTRB;
    assign w_commit  = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs) & ~r_bvalid;

    assign w_start_req = w_commit & (w_wr_addr == IW'(4)) & w_wr_strb[0] & w_wr_data[0] & ~r_busy;
    assign w_done_clr  = w_commit & (w_wr_addr == IW'(5)) & w_wr_strb[0] & w_wr_data[1];
    // A completion with no operation in flight (e.g. straddling a reset) is dropped.
    assign w_core_done = des_done & r_busy;

    assign w_unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    always_comb begin
        w_rd_mux = '0;
        case (s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2])
            IW'(0):  w_rd_mux = r_key_hi;
            IW'(1):  w_rd_mux = r_key_lo;
            IW'(2):  w_rd_mux = r_din_hi;
            IW'(3):  w_rd_mux = r_din_lo;
            IW'(4):  w_rd_mux = {{(DW-2){1'b0}}, r_decrypt, 1'b0};
            IW'(5):  w_rd_mux = {{(DW-2){1'b0}}, r_done, r_busy};
            IW'(6):  w_rd_mux = r_res_hi;
            default: w_rd_mux = r_res_lo;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rdy_en  <= 1'b0;
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_commit) begin
                r_aw_full <= 1'b0;
            end else if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_commit) begin
                r_w_full <= 1'b0;
            end else if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= s_axi.S_AXI_WDATA;
                r_w_strb <= s_axi.S_AXI_WSTRB;
            end
            if (w_commit) r_bvalid <= 1'b1;
            else if (s_axi.S_AXI_BREADY) r_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
        end else if (s_axi.S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_key_hi  <= '0;
            r_key_lo  <= '0;
            r_din_hi  <= '0;
            r_din_lo  <= '0;
            r_decrypt <= 1'b0;
        end else if (w_commit) begin
            case (w_wr_addr)
                IW'(0): r_key_hi <= f_merge(r_key_hi, w_wr_data, w_wr_strb);
                IW'(1): r_key_lo <= f_merge(r_key_lo, w_wr_data, w_wr_strb);
                IW'(2): r_din_hi <= f_merge(r_din_hi, w_wr_data, w_wr_strb);
                IW'(3): r_din_lo <= f_merge(r_din_lo, w_wr_data, w_wr_strb);
                IW'(4): if (w_wr_strb[0]) r_decrypt <= w_wr_data[1];
                default: ;
            endcase
        end
    end

    // Core handshake: start pulse, busy/done tracking and result capture.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else begin
            r_start <= w_start_req;
            if (w_core_done) r_busy <= 1'b0;
            else if (w_start_req) r_busy <= 1'b1;
            if (w_core_done) r_done <= 1'b1;
            else if (w_done_clr) r_done <= 1'b0;
            if (w_core_done) begin
                r_res_hi <= des_dout[63:32];
                r_res_lo <= des_dout[31:0];
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = w_awready;
    assign s_axi.S_AXI_WREADY  = w_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = w_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = 2'b00;

    assign des_key     = {r_key_hi, r_key_lo};
    assign des_din     = {r_din_hi, r_din_lo};
    assign des_decrypt = r_decrypt;
    assign des_start   = r_start;
endmodule

// File: tb/tb_desip_axil_slave.sv
// Scoreboard bench for the DES AXI4-Lite front-end: expected read data and write
// responses are queued at issue and checked by a monitor on each handshake.
module tb_desip_axil_slave;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [63:0] des_key, des_din, des_dout;
    logic        des_decrypt, des_start, des_done;

    always #5 ACLK = ~ACLK;

    desip_axil_slave_if bus ();

    desip_axil_slave dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .s_axi       (bus.slave),
        .des_key     (des_key),
        .des_din     (des_din),
        .des_decrypt (des_decrypt),
        .des_start   (des_start),
        .des_done    (des_done),
        .des_dout    (des_dout)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          start_cnt = 0;
    logic [31:0] q_rd[$];
    logic [1:0]  q_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations on every R and B handshake; counts start pulse cycles.
    always @(negedge ACLK) begin
        if (ARESETN && bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
            if (q_rd.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL rd_unexpected: got 0x%0h expected none", bus.S_AXI_RDATA);
            end else begin
                check("rdata", bus.S_AXI_RDATA, q_rd.pop_front());
                check("rresp", bus.S_AXI_RRESP, 2'b00);
            end
        end
        if (ARESETN && bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
            if (q_b.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL b_unexpected: got bresp %0d expected none", bus.S_AXI_BRESP);
            end else begin
                check("bresp", bus.S_AXI_BRESP, q_b.pop_front());
            end
        end
        if (des_start) start_cnt++;
    end

    task automatic wait_b();
        bit got = 0;
        bus.S_AXI_BREADY = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge ACLK);
            got = bus.S_AXI_BVALID;
            @(posedge ACLK); #1;
        end
        bus.S_AXI_BREADY = 1'b0;
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL b_timeout: got no BVALID expected BVALID within 40 cycles");
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_ok = 0;
        bit w_ok = 0;
        bit hs_a, hs_w;
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        q_b.push_back(2'b00);
        for (int n = 0; n < 40 && !(aw_ok && w_ok); n++) begin
            @(negedge ACLK);
            hs_a = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            hs_w = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (hs_a) begin aw_ok = 1; bus.S_AXI_AWVALID = 1'b0; end
            if (hs_w) begin w_ok = 1; bus.S_AXI_WVALID = 1'b0; end
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        if (!(aw_ok && w_ok)) begin
            n_chk++; n_err++;
            $display("FAIL wr_timeout: got aw=%0d w=%0d expected both accepted", aw_ok, w_ok);
        end else begin
            wait_b();
        end
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] exp);
        bit ok = 0;
        q_rd.push_back(exp);
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge ACLK);
            ok = bus.S_AXI_ARREADY;
            @(posedge ACLK); #1;
        end
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b1;
        ok = ok ? 1'b0 : 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge ACLK);
            ok = bus.S_AXI_RVALID;
            @(posedge ACLK); #1;
        end
        bus.S_AXI_RREADY = 1'b0;
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL rd_timeout: got no RVALID expected RVALID for addr 0x%0h", a);
        end
    endtask

    task automatic pulse_done(input logic [63:0] v);
        des_dout = v;
        des_done = 1'b1;
        @(posedge ACLK); #1;
        des_done = 1'b0;
    endtask

    initial begin
        int s0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        des_done = 1'b0; des_dout = '0;

        repeat (2) @(posedge ACLK);
        #1;
        check("rst_awready", bus.S_AXI_AWREADY, 0);
        check("rst_wready",  bus.S_AXI_WREADY, 0);
        check("rst_arready", bus.S_AXI_ARREADY, 0);
        check("rst_bvalid",  bus.S_AXI_BVALID, 0);
        check("rst_rvalid",  bus.S_AXI_RVALID, 0);
        check("rst_start",   des_start, 0);
        check("rst_key",     des_key, 64'h0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // Basic register writes and readback
        axi_write(5'h00, 32'h1, 4'hF);
        axi_write(5'h04, 32'h2, 4'hF);
        axi_write(5'h08, 32'h3, 4'hF);
        axi_write(5'h0C, 32'h4, 4'hF);
        axi_read(5'h00, 32'h1);
        axi_read(5'h04, 32'h2);
        axi_read(5'h08, 32'h3);
        axi_read(5'h0C, 32'h4);
        check("des_key", des_key, 64'h0000000100000002);
        check("des_din", des_din, 64'h0000000300000004);

        // Byte strobes
        axi_write(5'h08, 32'h11223344, 4'hF);
        axi_write(5'h08, 32'hAABBCCDD, 4'h5);
        axi_read(5'h08, 32'h11BB33DD);

        // AW at cycle 0, W at cycle 3, BREADY at cycle 8
        bus.S_AXI_AWADDR = 5'h0C;
        bus.S_AXI_WDATA  = 32'h55AA55AA;
        bus.S_AXI_WSTRB  = 4'hF;
        q_b.push_back(2'b00);
        for (int c = 0; c < 10; c++) begin
            bus.S_AXI_AWVALID = (c == 0);
            bus.S_AXI_WVALID  = (c == 3);
            bus.S_AXI_BREADY  = (c == 8);
            @(negedge ACLK);
            check($sformatf("bvalid_c%0d", c), bus.S_AXI_BVALID, (c >= 4 && c <= 8));
            check($sformatf("awready_c%0d", c), bus.S_AXI_AWREADY, (c == 0 || c == 9));
            @(posedge ACLK); #1;
        end
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
        axi_read(5'h0C, 32'h55AA55AA);

        // Start pulse and busy
        s0 = start_cnt;
        axi_write(5'h10, 32'h3, 4'hF);
        repeat (3) @(posedge ACLK);
        #1;
        check("start_pulses", start_cnt - s0, 1);
        check("decrypt_out", des_decrypt, 1);
        axi_read(5'h14, 32'h1);
        axi_read(5'h10, 32'h2);
        axi_write(5'h10, 32'h1, 4'hF);
        repeat (3) @(posedge ACLK);
        #1;
        check("start_while_busy", start_cnt - s0, 1);

        // Completion, result capture, write-1-clear
        pulse_done(64'h85E813540F0AB405);
        axi_read(5'h14, 32'h2);
        axi_read(5'h18, 32'h85E81354);
        axi_read(5'h1C, 32'h0F0AB405);
        axi_write(5'h14, 32'h2, 4'hF);
        axi_read(5'h14, 32'h0);

        // DONE clear coincident with des_done: set wins
        s0 = start_cnt;
        axi_write(5'h10, 32'h1, 4'hF);
        repeat (2) @(posedge ACLK);
        #1;
        check("start_again", start_cnt - s0, 1);
        bus.S_AXI_AWADDR = 5'h14; bus.S_AXI_WDATA = 32'h2; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        des_dout = 64'h0123456789ABCDEF; des_done = 1'b1;
        q_b.push_back(2'b00);
        @(negedge ACLK);
        check("coinc_awready", bus.S_AXI_AWREADY, 1);
        check("coinc_wready", bus.S_AXI_WREADY, 1);
        @(posedge ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; des_done = 1'b0;
        wait_b();
        axi_read(5'h14, 32'h2);
        axi_read(5'h1C, 32'h89ABCDEF);

        // Reset while BVALID and BUSY are high
        axi_write(5'h10, 32'h3, 4'hF);
        bus.S_AXI_AWADDR = 5'h00; bus.S_AXI_WDATA = 32'hCAFEF00D; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        @(posedge ACLK); #1;
        check("pre_rst_bvalid", bus.S_AXI_BVALID, 1);
        #2 ARESETN = 1'b0;
        #1;
        check("mid_rst_bvalid", bus.S_AXI_BVALID, 0);
        check("mid_rst_awready", bus.S_AXI_AWREADY, 0);
        check("mid_rst_arready", bus.S_AXI_ARREADY, 0);
        check("mid_rst_start", des_start, 0);
        check("mid_rst_key", des_key, 64'h0);
        check("mid_rst_din", des_din, 64'h0);
        check("mid_rst_decrypt", des_decrypt, 0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        pulse_done(64'hFFFF0000FFFF0000);
        axi_read(5'h00, 32'h0);
        axi_read(5'h04, 32'h0);
        axi_read(5'h08, 32'h0);
        axi_read(5'h0C, 32'h0);
        axi_read(5'h10, 32'h0);
        axi_read(5'h14, 32'h0);
        axi_read(5'h18, 32'h0);
        axi_read(5'h1C, 32'h0);

        repeat (2) @(posedge ACLK);
        check("rd_queue_left", q_rd.size(), 0);
        check("b_queue_left", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
